// File: rtl/boot_memory.sv
`timescale 1ns/1ps
// Loader-fed 256-byte program memory: receives a LEN/DATA/CHK frame, then serves instruction fetches.
// Latency: fetch data registered one cycle after a strobed edge; cpuRun rises one cycle after a good CHK.
// Backpressure: loadReady is high in every loading state and drops for good once a valid frame is in RAM.
module boot_memory #(
    parameter logic [7:0] LOAD_BASE = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] memAddr,
    input  logic       memStrobe,
    output logic [7:0] memDataRead,
    input  logic       loadValid,
    input  logic [7:0] loadData,
    output logic       loadReady,
    output logic       cpuRun,
    output logic       loadError
);

    typedef enum logic [1:0] {
        ST_LEN  = 2'd0,
        ST_DATA = 2'd1,
        ST_CHK  = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    state_t     state;
    state_t     stateNext;

    // count is 9 bits so a LEN byte of zero can stand for a full 256-byte image
    logic [8:0] count;
    logic [8:0] countNext;
    logic [7:0] addr;
    logic [7:0] addrNext;
    logic [7:0] sum;
    logic [7:0] sumNext;
    logic       loadErrorNext;
    logic       ramWe;
    logic       xfer;
    logic [7:0] chkSum;

    logic [7:0] ram [256];

    // A loader byte moves whenever both sides agree; RUN is the only state that refuses bytes
    assign loadReady = (state != ST_RUN);
    assign xfer      = loadValid && loadReady;
    assign chkSum    = sum + loadData;

    // Frame parser: next-state, running address/sum/count and the RAM write strobe
    always_comb begin
        stateNext     = state;
        countNext     = count;
        addrNext      = addr;
        sumNext       = sum;
        loadErrorNext = loadError;
        ramWe         = 1'b0;
        case (state)
            ST_LEN: begin
                if (xfer) begin
                    countNext = (loadData == 8'h00) ? 9'd256 : {1'b0, loadData};
                    addrNext  = LOAD_BASE;
                    sumNext   = 8'h00;
                    stateNext = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    ramWe     = 1'b1;
                    addrNext  = addr + 8'd1;
                    sumNext   = sum + loadData;
                    countNext = count - 9'd1;
                    if (count == 9'd1) begin
                        stateNext = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (xfer) begin
                    if (chkSum == 8'h00) begin
                        loadErrorNext = 1'b0;
                        stateNext     = ST_RUN;
                    end else begin
                        // bad image: flag it and wait for the loader to retry from LEN
                        loadErrorNext = 1'b1;
                        stateNext     = ST_LEN;
                    end
                end
            end
            ST_RUN: begin
                stateNext = ST_RUN;
            end
            default: begin
                stateNext = ST_LEN;
            end
        endcase
    end

    // Control registers; cpuRun is taken from the registered RUN state so it lags the CHK edge by one
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_LEN;
            count     <= 9'd0;
            addr      <= LOAD_BASE;
            sum       <= 8'h00;
            loadError <= 1'b0;
            cpuRun    <= 1'b0;
        end else begin
            state     <= stateNext;
            count     <= countNext;
            addr      <= addrNext;
            sum       <= sumNext;
            loadError <= loadErrorNext;
            cpuRun    <= (state == ST_RUN);
        end
    end

    // RAM write port; contents deliberately survive reset so a partial image is not wiped
    always_ff @(posedge clk) begin
        if (ramWe && !reset) begin
            ram[addr] <= loadData;
        end
    end

    // RAM read port; only live in RUN, so it can never collide with a loader write
    always_ff @(posedge clk) begin
        if (reset) begin
            memDataRead <= 8'h00;
        end else if ((state == ST_RUN) && memStrobe) begin
            memDataRead <= ram[memAddr];
        end
    end

endmodule
